// File: rtl/sha256_pkg.sv
// Shared constants and FSM encoding for the SHA-256 message padder and its
// neighbours in the hashing datapath.
package sha256_pkg;

  localparam int             SHA256_BLOCK_W  = 512;
  localparam int             SHA256_WORD_W   = 32;
  localparam logic [7:0]     SHA256_PAD_MARK = 8'h80;
  localparam int             SHA256_LEN_POS  = 56;
  localparam int             SHA256_WORDS    = SHA256_BLOCK_W / SHA256_WORD_W;

  typedef enum logic [1:0] {
    ST_FILL,
    ST_PAD,
    ST_EMIT,
    ST_XTRA
  } pad_state_t;

endpackage

// File: rtl/sha256_pad_word.sv
// Final-word shaper: keeps the valid leading bytes of a big-endian word,
// drops the 0x80 marker right after them and zeroes the remainder.
module sha256_pad_word
  import sha256_pkg::*;
(
  input  logic [SHA256_WORD_W-1:0] word,
  input  logic [2:0]               nbytes,
  output logic [SHA256_WORD_W-1:0] padded
);

  // NOTE: every output of a combinational block gets a default before the
  // case so that no path leaves it unassigned and a latch is never inferred.
  always_comb begin
    padded = word;
    unique case (nbytes)
      3'd0:    padded = {SHA256_PAD_MARK, 24'h0};
      3'd1:    padded = {word[31:24], SHA256_PAD_MARK, 16'h0};
      3'd2:    padded = {word[31:16], SHA256_PAD_MARK, 8'h0};
      3'd3:    padded = {word[31:8], SHA256_PAD_MARK};
      default: padded = word;  // full word: the marker lands in the next word
    endcase
  end

endmodule

// File: rtl/sha256_padder.sv
// Collects a big-endian word stream into 512-bit blocks and applies SHA-256
// message padding (marker, zero fill, 64-bit bit length) to the final block.
module sha256_padder
  import sha256_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SHA256_WORD_W-1:0]  in_data,
  input  logic                      in_last,
  input  logic [2:0]                in_nbytes,
  output logic                      blk_valid,
  input  logic                      blk_ready,
  output logic [SHA256_BLOCK_W-1:0] blk_data,
  output logic                      blk_first,
  output logic                      blk_last,
  output logic                      busy
);

  localparam logic [SHA256_WORD_W-1:0] MARK_WORD = {SHA256_PAD_MARK, 24'h0};

  pad_state_t               state, state_next;
  logic [SHA256_WORD_W-1:0] words_q [SHA256_WORDS];
  logic [3:0]               widx;
  logic [LEN_W-1:0]         count;
  logic                     extra;
  logic                     mark_done;

  logic [SHA256_WORD_W-1:0] pad_word;
  logic [2:0]               nbytes_c;
  logic [LEN_W-1:0]         add_bytes;
  logic                     in_fire;
  logic [5:0]               pos;
  logic [3:0]               mark_idx;
  logic                     full;
  logic [LEN_W-1:0]         bit_len;
  logic [63:0]              len_field;

  sha256_pad_word u_pad_word (
    .word   (in_data),
    .nbytes (nbytes_c),
    .padded (pad_word)
  );

  assign nbytes_c  = (in_nbytes > 3'd4) ? 3'd4 : in_nbytes;
  assign add_bytes = in_last ? LEN_W'(nbytes_c) : LEN_W'(3'd4);
  assign in_fire   = in_valid && in_ready;

  // Marker byte position inside the block; a last word that fills word 15
  // completely wraps widx to 0 with pos 0, and the marker moves to an extra block.
  assign pos       = count[5:0];
  assign mark_idx  = pos[5:2];
  assign full      = (pos == 6'd0) && (widx == 4'd0);
  assign bit_len   = count << 3;
  assign len_field = 64'(bit_len);

  // NOTE: the state register uses non-blocking assignment so every flop
  // samples pre-edge values; combinational logic uses blocking assignment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_FILL;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    blk_valid  = 1'b0;
    unique case (state)
      ST_FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (in_last)             state_next = ST_PAD;
          else if (widx == 4'd15)  state_next = ST_EMIT;
        end
      end
      ST_PAD:  state_next = ST_EMIT;
      ST_EMIT: begin
        blk_valid = 1'b1;
        if (blk_ready) state_next = extra ? ST_XTRA : ST_FILL;
      end
      ST_XTRA: state_next = ST_EMIT;
      default: state_next = ST_FILL;
    endcase
  end

  // NOTE: the word buffer is reset because it drives blk_data directly and
  // must read as zero out of reset, not just whenever blk_valid is high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SHA256_WORDS; i++) words_q[i] <= '0;
      widx      <= '0;
      count     <= '0;
      extra     <= 1'b0;
      mark_done <= 1'b0;
      blk_first <= 1'b1;
      blk_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        ST_FILL: begin
          if (in_fire) begin
            words_q[widx] <= in_last ? pad_word : in_data;
            widx          <= widx + 4'd1;
            count         <= count + add_bytes;
            busy          <= 1'b1;
          end
        end
        ST_PAD: begin
          if (full) begin
            extra     <= 1'b1;
            mark_done <= 1'b0;
          end else begin
            for (int i = 0; i < SHA256_WORDS; i++) begin
              if (4'(i) == mark_idx && pos[1:0] == 2'd0) words_q[i] <= MARK_WORD;
              else if (4'(i) > mark_idx)                  words_q[i] <= '0;
            end
            if (pos < 6'(SHA256_LEN_POS)) begin
              words_q[14] <= len_field[63:32];
              words_q[15] <= len_field[31:0];
              blk_last    <= 1'b1;
            end else begin
              extra     <= 1'b1;
              mark_done <= 1'b1;
            end
          end
        end
        ST_EMIT: begin
          if (blk_ready) begin
            blk_first <= 1'b0;
            if (extra) begin
              extra <= 1'b0;
            end else if (blk_last) begin
              blk_last  <= 1'b0;
              blk_first <= 1'b1;
              busy      <= 1'b0;
              count     <= '0;
              widx      <= '0;
              mark_done <= 1'b0;
            end else begin
              widx <= '0;
            end
          end
        end
        ST_XTRA: begin
          for (int i = 0; i < SHA256_WORDS; i++) words_q[i] <= '0;
          words_q[0]  <= mark_done ? '0 : MARK_WORD;
          words_q[14] <= len_field[63:32];
          words_q[15] <= len_field[31:0];
          blk_last    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    blk_data = '0;
    for (int i = 0; i < SHA256_WORDS; i++)
      blk_data[SHA256_BLOCK_W-1-SHA256_WORD_W*i -: SHA256_WORD_W] = words_q[i];
  end

endmodule

// File: tb/tb_sha256_padder.sv
// Directed bench for sha256_padder: known messages with hand-computed padded
// blocks, block sequencing flags, backpressure and mid-message reset.
module tb_sha256_padder;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_last;
  logic [2:0]   in_nbytes;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_first;
  logic         blk_last;
  logic         busy;

  int checks = 0;
  int errors = 0;

  logic [511:0] got_data [$];
  logic         got_first[$];
  logic         got_last [$];

  always #5 clk = ~clk;

  sha256_padder #(.LEN_W(64)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_nbytes (in_nbytes),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .blk_first (blk_first),
    .blk_last  (blk_last),
    .busy      (busy)
  );

  // Record every block that will be taken at the coming rising edge.
  always @(negedge clk) begin
    if (reset_n && blk_valid && blk_ready) begin
      got_data.push_back(blk_data);
      got_first.push_back(blk_first);
      got_last.push_back(blk_last);
    end
  end

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    errors++;
    $error("FAIL %s timed out", tag);
  endtask

  function automatic logic [31:0] pat(input int i);
    return 32'(i + 1) * 32'h01010101;
  endfunction

  function automatic logic [511:0] put(input logic [511:0] b, input int idx, input logic [31:0] w);
    logic [511:0] r = b;
    r[511-32*idx -: 32] = w;
    return r;
  endfunction

  function automatic logic [511:0] data_words(input int first, input int n);
    logic [511:0] r = '0;
    for (int k = 0; k < n; k++) r[511-32*k -: 32] = pat(first + k);
    return r;
  endfunction

  task automatic send_word(input logic [31:0] d, input logic last, input logic [2:0] nb);
    int cyc = 0;
    in_valid = 1'b1; in_data = d; in_last = last; in_nbytes = nb;
    while (!in_ready && cyc < 200) begin @(posedge clk); #1; cyc++; end
    if (!in_ready) timeout("send_word");
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_nbytes = '0;
  endtask

  // Message of n bytes; byte values come from pat(), junk sits in unused bytes.
  task automatic send_msg(input int n);
    int nfull = n / 4;
    int rem   = n % 4;
    if (rem == 0 && n > 0) begin
      for (int k = 0; k < nfull - 1; k++) send_word(pat(k), 1'b0, 3'd0);
      send_word(pat(nfull - 1), 1'b1, 3'd4);
    end else begin
      for (int k = 0; k < nfull; k++) send_word(pat(k), 1'b0, 3'd0);
      send_word(pat(nfull), 1'b1, 3'(rem));
    end
  endtask

  task automatic wait_blocks(input int n);
    int cyc = 0;
    while (got_data.size() < n && cyc < 500) begin @(posedge clk); #1; cyc++; end
    if (got_data.size() < n) timeout("wait_blocks");
  endtask

  task automatic wait_valid();
    int cyc = 0;
    while (!blk_valid && cyc < 100) begin @(posedge clk); #1; cyc++; end
    if (!blk_valid) timeout("wait_valid");
  endtask

  task automatic check_blk(input string tag, input int idx, input logic [511:0] exp,
                           input logic f, input logic l);
    if (idx < got_data.size()) begin
      check({tag, "_data"},  got_data[idx],  exp);
      check({tag, "_first"}, got_first[idx], f);
      check({tag, "_last"},  got_last[idx],  l);
    end else begin
      timeout({tag, "_missing"});
    end
  endtask

  task automatic clear_blocks();
    got_data.delete(); got_first.delete(); got_last.delete();
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    in_nbytes = '0; blk_ready = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  in_ready,  1'b1);
    check("rst_blk_valid", blk_valid, 1'b0);
    check("rst_blk_first", blk_first, 1'b1);
    check("rst_blk_last",  blk_last,  1'b0);
    check("rst_busy",      busy,      1'b0);
    check("rst_blk_data",  blk_data,  512'h0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // "abc": final block appears two cycles after the last handshake
    send_word(32'h61626300, 1'b1, 3'd3);
    check("abc_busy",      busy,      1'b1);
    check("abc_pad_cycle", blk_valid, 1'b0);
    @(posedge clk); #1;
    check("abc_valid",     blk_valid, 1'b1);
    check("abc_live_data", blk_data,  put(put(512'h0, 0, 32'h61626380), 15, 32'h18));
    check("abc_live_first", blk_first, 1'b1);
    check("abc_live_last",  blk_last,  1'b1);
    blk_ready = 1'b1;
    wait_blocks(1);
    check("abc_nblk",      32'(got_data.size()), 32'd1);
    check_blk("abc", 0, put(put(512'h0, 0, 32'h61626380), 15, 32'h18), 1'b1, 1'b1);
    check("abc_idle_busy",  busy,      1'b0);
    check("abc_rearm_first", blk_first, 1'b1);
    check("abc_in_ready",   in_ready,  1'b1);
    clear_blocks();

    // Empty message
    send_msg(0);
    wait_blocks(1);
    check("empty_nblk", 32'(got_data.size()), 32'd1);
    check_blk("empty", 0, put(512'h0, 0, 32'h80000000), 1'b1, 1'b1);
    clear_blocks();

    // 55 bytes: marker fits with the length in one block
    send_msg(55);
    wait_blocks(1);
    check("b55_nblk", 32'(got_data.size()), 32'd1);
    check_blk("b55", 0, put(put(data_words(0, 13), 13, 32'h0E0E0E80), 15, 32'h000001B8),
              1'b1, 1'b1);
    clear_blocks();

    // 56 bytes: length spills into an extra block two cycles after handshake
    blk_ready = 1'b0;
    send_msg(56);
    wait_valid();
    check("b56_first_live", blk_first, 1'b1);
    check("b56_last_live",  blk_last,  1'b0);
    blk_ready = 1'b1;
    @(posedge clk); #1;
    check("b56_xtra_gap",   blk_valid, 1'b0);
    @(posedge clk); #1;
    check("b56_xtra_valid", blk_valid, 1'b1);
    wait_blocks(2);
    check("b56_nblk", 32'(got_data.size()), 32'd2);
    check_blk("b56_blk0", 0, put(data_words(0, 14), 14, 32'h80000000), 1'b1, 1'b0);
    check_blk("b56_blk1", 1, put(512'h0, 15, 32'h000001C0), 1'b0, 1'b1);
    clear_blocks();

    // 64 bytes: data block verbatim, marker and length in the extra block
    send_msg(64);
    wait_blocks(2);
    check("b64_nblk", 32'(got_data.size()), 32'd2);
    check_blk("b64_blk0", 0, data_words(0, 16), 1'b1, 1'b0);
    check_blk("b64_blk1", 1, put(put(512'h0, 0, 32'h80000000), 15, 32'h00000200), 1'b0, 1'b1);
    clear_blocks();

    // Backpressure on the first data block of a 130-byte message
    blk_ready = 1'b0;
    for (int k = 0; k < 16; k++) send_word(pat(k), 1'b0, 3'd0);
    check("bp_valid_next", blk_valid, 1'b1);
    for (int c = 0; c < 10; c++) begin
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_hold_data", blk_data, data_words(0, 16));
      @(posedge clk); #1;
    end
    blk_ready = 1'b1;
    for (int k = 16; k < 32; k++) send_word(pat(k), 1'b0, 3'd0);
    send_word(pat(32), 1'b1, 3'd2);
    wait_blocks(3);
    check("b130_nblk", 32'(got_data.size()), 32'd3);
    check_blk("b130_blk0", 0, data_words(0, 16), 1'b1, 1'b0);
    check_blk("b130_blk1", 1, data_words(16, 16), 1'b0, 1'b0);
    check_blk("b130_blk2", 2, put(put(512'h0, 0, 32'h21218000), 15, 32'h00000410), 1'b0, 1'b1);
    clear_blocks();

    // Reset mid-FILL after 7 words, then a clean "abc"
    for (int k = 0; k < 7; k++) send_word(pat(k), 1'b0, 3'd0);
    check("mid_busy", busy, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_in_ready",  in_ready,  1'b1);
    check("mid_rst_blk_valid", blk_valid, 1'b0);
    check("mid_rst_blk_first", blk_first, 1'b1);
    check("mid_rst_blk_last",  blk_last,  1'b0);
    check("mid_rst_busy",      busy,      1'b0);
    check("mid_rst_blk_data",  blk_data,  512'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    send_word(32'h61626300, 1'b1, 3'd3);
    wait_blocks(1);
    check("post_rst_nblk", 32'(got_data.size()), 32'd1);
    check_blk("post_rst_abc", 0, put(put(512'h0, 0, 32'h61626380), 15, 32'h18), 1'b1, 1'b1);
    clear_blocks();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha256_padder.md
# sha256_padder

Upstream message-formatting stage for the SHA-256 datapath. Accepts an arbitrary-length byte message as a stream of big-endian 32-bit words and emits 512-bit blocks with FIPS 180-4 padding (0x80 marker, zero fill, 64-bit big-endian bit length). Each block goes to the core / `sha256_w_mem` `block` input, with first/last flags that drive `init`/`next` sequencing. Sits between the HSM message bus and `sha256_core`.

## Interface
- `LEN_W`, 64: width of the internal bit-length counter. Legal range is 32..64. The value is zero-extended into the 64-bit length field.
- `clk`  in  1  system clock
- `reset_n`  in  1  reset; asynchronous, active-low
- `in_valid`  in  1  input word valid
- `in_ready`  out  1  padder accepts input word
- `in_data`  in  32  message word; the first message byte is in [31:24]
- `in_last`  in  1  this word ends the message
- `in_nbytes`  in  3  valid bytes in the last word, 0..4. Ignored unless `in_last`. A value of 0 means no data bytes: the word carries nothing, which is how an empty message is signalled.
- `blk_valid`  out  1  `blk_data` holds a complete block
- `blk_ready`  in  1  consumer takes the block
- `blk_data`  out  512  block; word 0 is in [511:480]
- `blk_first`  out  1  block is the first of its message (consumer pulses `init`)
- `blk_last`  out  1  block is the final padded block (digest valid after it)
- `busy`  out  1  a message is in progress or a block is pending

## Operation
- Buffer: 16×32 word registers, 4-bit word index `widx`, `LEN_W`-bit byte counter, and an `extra` flag.
- FSM states:
  - **FILL**
    - `in_ready` = 1.
    - Each handshake writes `in_data` to `buf[widx]`, increments `widx`, and adds 4 to the byte count (or `in_nbytes` if `in_last`).
    - Non-last word at `widx`=15 → EMIT (data block).
    - Last word → PAD.
  - **PAD**, one cycle.
    - Marker position is `p` = byte count mod 64.
    - Byte `p` = 0x80; all bytes after `p` in the block are zeroed.
    - If `p` ≤ 55: words 14–15 = bit length (bytes×8, big-endian). Set `blk_last`. → EMIT.
    - Else: set `extra`. → EMIT.
    - If the last word completes the block exactly (`p`=0 with count>0), PAD first emits the full data block unmodified with `extra` set. The marker then goes in the extra block.
  - **EMIT**
    - `blk_valid` = 1; `in_ready` = 0.
    - On `blk_ready`: clear `blk_first`.
    - If `extra` → XTRA; else if `blk_last` → FILL (idle, `blk_first` re-armed); else → FILL, `widx`=0.
  - **XTRA**, one cycle.
    - Buffer cleared.
    - Marker at byte 0 only if it was not yet placed.
    - Words 14–15 = length; `blk_last`=1. → EMIT.
- Length arithmetic wraps modulo 2^`LEN_W`. There is no error on overflow.
- `busy` = 1 from the first accepted word until the `blk_last` handshake.

## Timing
- Reset (async, any state):
  - FSM → FILL.
  - `in_ready`=1, `blk_valid`=0, `blk_first`=1, `blk_last`=0, `busy`=0.
  - `blk_data`=0, counters 0.
  - A message in flight is discarded.
- Data block: `blk_valid` rises the cycle after the 16th word handshake.
- Final block: `blk_valid` rises 2 cycles after the `in_last` handshake (PAD, then EMIT).
- Extra block: `blk_valid` rises 2 cycles after the previous block's handshake.
- `blk_data`, `blk_first`, and `blk_last` are stable while `blk_valid`=1 and `blk_ready`=0.
- There is no combinational path from `blk_ready` to `in_ready`.
- Peak throughput: 1 word/cycle, plus 1 cycle per emitted block.

## Structure
- Shared package `sha256_pkg`: `SHA256_BLOCK_W`=512, `SHA256_WORD_W`=32, `SHA256_PAD_MARK`=8'h80, `SHA256_LEN_POS`=56, and the padder FSM state enum.
- One natural sub-module, `sha256_pad_word`. It is combinational: from a word and `in_nbytes`, it returns the masked word with the marker inserted.
- Everything else stays in the top.

## Test plan
- "abc" as one word 0x61626300 with `in_last`, `in_nbytes`=3 → one block = 0x61626380, 13 zero words, 0x00000000, 0x00000018; `blk_first`=`blk_last`=1. Feeding it to `sha256_w_mem` gives W[16]=0x61626380.
- Empty message (`in_last`, `in_nbytes`=0) → one block, word 0=0x80000000, all else 0, length 0.
- 55-byte message → single block; byte 55=0x80; word 15=0x000001B8. 56-byte message → two blocks; the second is all-zero except word 15=0x000001C0 and is the only one with `blk_last`.
- 64-byte message → block 1 = data verbatim (`blk_first`=1, `blk_last`=0); block 2 = 0x80000000, zeros, word 15=0x00000200.
- Backpressure: hold `blk_ready`=0 for 10 cycles → `in_ready`=0 and `blk_data` unchanged throughout. A 130-byte message yields 3 blocks in order.
- Assert `reset_n`=0 mid-FILL after 7 words → outputs take reset values immediately. The following "abc" produces the correct single block with `blk_first`=1.
